// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, synchronous flush and a NOP bubble payload.
// Define PIPE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int                DATA_W      = 108,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Handshake: a payload moves across a port only on a rising edge where
    // that port's valid and ready are both 1; out_data never changes while
    // out_valid=1 and out_ready=0 unless flush or rst discards it.
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              in_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    assign in_ready = !skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_DATA;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE_DATA;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (out_ready) begin
            // The skid entry is always older than anything still upstream.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_DATA;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE_DATA;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Single entry: space frees up in the same cycle the downstream consumes.
    assign in_ready = !main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_DATA;
        end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_DATA;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue model of the held entries.
module tb_pipe_stage_reg;
    localparam int              W   = 108;
    localparam logic [W-1:0]    BUB = 108'h0_0000_0000_0000_0000_0000_BEEF;
`ifdef PIPE_SKID_EN
    localparam int              CAP = 2;
`else
    localparam int              CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: held payloads oldest first, plus the last payload shown when empty.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data = BUB;

    pipe_stage_reg #(.DATA_W(W), .BUBBLE_DATA(BUB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic bit m_in_ready();
        if (CAP == 2) return exp_q.size() < 2;
        return exp_q.size() == 0 || out_ready;
    endfunction

    function automatic logic [W-1:0] m_out_data();
        return (exp_q.size() > 0) ? exp_q[0] : last_data;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples.
    always @(posedge clk) begin
        bit rdy;
        if (rst || flush) begin
            exp_q.delete();
            last_data = BUB;
        end else begin
            rdy = m_in_ready();
            if (exp_q.size() > 0 && out_ready) last_data = exp_q.pop_front();
            if (in_valid && rdy) exp_q.push_back(in_data);
        end
    end

    // Per-cycle compare, away from the active edge.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", W'(out_valid), W'(exp_q.size() > 0));
            chk("out_data", out_data, m_out_data());
            chk("in_ready", W'(in_ready), W'(m_in_ready()));
            if (prev_stall) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready && !flush && !rst;
            prev_data  = out_data;
        end
    end

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        cyc(0, '0, 1, 0);
        chk_en = 1'b1;
        cyc(0, '0, 1, 0);
        chk("rst_valid", W'(out_valid), W'(0));
        chk("rst_data", out_data, BUB);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Streaming 1..4 with no gaps.
        for (int i = 1; i <= 4; i++) begin
            cyc(1, W'(i), 1, 0);
            chk("stream_valid", W'(out_valid), W'(1));
            chk("stream_data", out_data, W'(i));
        end
        cyc(0, '0, 1, 0);
        chk("drain_valid", W'(out_valid), W'(0));
        chk("drain_keep", out_data, W'(4));

        // Backpressure with 0xA5 held.
        cyc(1, W'('hA5), 0, 0);
        in_data = W'('h5A);
        #1;
        chk("bp_in_ready0", W'(in_ready), W'(CAP == 2));
        cyc(1, W'('h5A), 0, 0);
        chk("bp_hold_data", out_data, W'('hA5));
        chk("bp_hold_valid", W'(out_valid), W'(1));
        chk("bp_in_ready1", W'(in_ready), W'(0));
        cyc(1, W'('h77), 0, 0);
        chk("bp_hold2", out_data, W'('hA5));
        cyc(1, W'('h5A), 1, 0);
        chk("bp_rel_data", out_data, W'('h5A));
        chk("bp_rel_valid", W'(out_valid), W'(1));
        cyc(0, '0, 1, 0);
        chk("bp_end_valid", W'(out_valid), W'(0));
        chk("bp_end_data", out_data, W'('h5A));

        // Flush overrides a same-cycle accepted input.
        cyc(1, W'('h11), 0, 0);
        chk("fl_full", out_data, W'('h11));
        cyc(1, W'('h22), 1, 1);
        chk("fl_valid", W'(out_valid), W'(0));
        chk("fl_data", out_data, BUB);
        cyc(0, '0, 1, 0);
        chk("fl_no22_valid", W'(out_valid), W'(0));
        chk("fl_no22_data", out_data, BUB);

`ifdef PIPE_SKID_EN
        // Flush during a stall with both entries full.
        cyc(1, W'('h33), 0, 0);
        cyc(1, W'('h44), 0, 0);
        chk("sk_full_in_ready", W'(in_ready), W'(0));
        cyc(0, '0, 0, 1);
        chk("sk_fl_valid", W'(out_valid), W'(0));
        chk("sk_fl_data", out_data, BUB);
        chk("sk_fl_in_ready", W'(in_ready), W'(1));
        cyc(0, '0, 1, 0);
        chk("sk_fl_empty", W'(out_valid), W'(0));
`endif

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0] d;
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            rst = ($urandom_range(0, 999) == 0);
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        chk("final_empty", W'(out_valid), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
